rv32i_dmem_responder: RTL

- Responder end of the RV32I datapath's data-memory port. It accepts the address, lane-positioned write data and byte-lane enables that the pipeline presents from its memory stage.
- Serves word RAM plus a small MMIO window: 64-bit cycle counter, tohost/halt register, scratch register.
- Returns a full 32-bit word one cycle later. The initiator performs byte/halfword extraction and sign extension.
- Flags illegal accesses on a registered error strobe.

---
 rtl/rv32i_dmem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for the RV32I pipeline: word RAM plus a small MMIO
// window (64-bit cycle counter, tohost/halt, scratch). Reads return the full
// word one cycle later. Illegal accesses raise a registered one-cycle error
// strobe and change no state.
module rv32i_dmem_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dmem_add_i,
  input  logic [31:0] dmem_di_i,
  input  logic [3:0]  dmem_ble_i,
  input  logic        dmem_we_i,
  input  logic        dmem_re_i,
  output logic [31:0] dmem_do_o,
  output logic        dmem_err_o,
  output logic [31:0] tohost_o,
  output logic        halt_o
);

  localparam logic [1:0] OFF_CYCLE   = 2'd0;
  localparam logic [1:0] OFF_CYCLEH  = 2'd1;
  localparam logic [1:0] OFF_TOHOST  = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;

  logic [31:0] ram [2**RAM_AW];

  logic [31:0] dmem_do_q, dmem_do_d;
  logic        dmem_err_q, dmem_err_d;
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] tohost_q, tohost_d;
  logic        halt_q, halt_d;
  logic [31:0] scratch_q, scratch_d;

  logic              ble_ok, access, is_ram, is_mmio, err, wr_ok, rd_ok;
  logic [1:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       bmask, rd_word;

  // Byte lanes are chosen by ble alone; the low address bits carry no meaning.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dmem_add_i[1:0];

  // Decode, legality checks and read-word selection.
  always_comb begin
    access   = dmem_we_i | dmem_re_i;
    is_ram   = (dmem_add_i[31:RAM_AW+2] == '0);
    is_mmio  = (dmem_add_i[31:4] == MMIO_BASE[31:4]);
    mmio_off = dmem_add_i[3:2];
    ram_idx  = dmem_add_i[RAM_AW+1:2];
    bmask    = {{8{dmem_ble_i[3]}}, {8{dmem_ble_i[2]}},
                {8{dmem_ble_i[1]}}, {8{dmem_ble_i[0]}}};

    unique case (dmem_ble_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ble_ok = 1'b1;
      default:                   ble_ok = 1'b0;
    endcase

    // MMIO registers are word-only and the counter words are read-only.
    err = access & (~ble_ok
                    | (dmem_we_i & dmem_re_i)
                    | ~(is_ram | is_mmio)
                    | (is_mmio & (dmem_ble_i != 4'b1111))
                    | (is_mmio & dmem_we_i & ~mmio_off[1]));
    wr_ok = dmem_we_i & ~err;
    rd_ok = dmem_re_i & ~err;

    rd_word = '0;
    if (is_ram) begin
      rd_word = ram[ram_idx];
    end else begin
      unique case (mmio_off)
        OFF_CYCLE:   rd_word = cycle_q[31:0];
        OFF_CYCLEH:  rd_word = cycle_q[63:32];
        OFF_TOHOST:  rd_word = tohost_q;
        OFF_SCRATCH: rd_word = scratch_q;
        default:     rd_word = '0;
      endcase
    end
  end

  // Next-state for the output registers, counter and MMIO registers.
  always_comb begin
    dmem_do_d  = dmem_do_q;
    dmem_err_d = err;
    cycle_d    = cycle_q + 64'd1;
    tohost_d   = tohost_q;
    halt_d     = halt_q;
    scratch_d  = scratch_q;

    if (rd_ok) begin
      dmem_do_d = rd_word;
    end else if (dmem_re_i && err) begin
      dmem_do_d = '0;
    end

    if (wr_ok && is_mmio) begin
      if (mmio_off == OFF_TOHOST) begin
        tohost_d = (tohost_q & ~bmask) | (dmem_di_i & bmask);
        halt_d   = halt_q | dmem_di_i[0];
      end else if (mmio_off == OFF_SCRATCH) begin
        scratch_d = (scratch_q & ~bmask) | (dmem_di_i & bmask);
      end
    end
  end

  // Register state; a reset also drops any read result still in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dmem_do_q  <= '0;
      dmem_err_q <= 1'b0;
      cycle_q    <= '0;
      tohost_q   <= '0;
      halt_q     <= 1'b0;
      scratch_q  <= '0;
    end else begin
      dmem_do_q  <= dmem_do_d;
      dmem_err_q <= dmem_err_d;
      cycle_q    <= cycle_d;
      tohost_q   <= tohost_d;
      halt_q     <= halt_d;
      scratch_q  <= scratch_d;
    end
  end

  // RAM lane writes; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_ok && is_ram) begin
      ram[ram_idx] <= (ram[ram_idx] & ~bmask) | (dmem_di_i & bmask);
    end
  end

  assign dmem_do_o  = dmem_do_q;
  assign dmem_err_o = dmem_err_q;
  assign tohost_o   = tohost_q;
  assign halt_o     = halt_q;

endmodule
